// File: rtl/mem_stage.sv
// Memory pipeline stage between execute and writeback.
// Scalar ops use a 16-bit data memory; bitmaps move over a narrower bus in BEATS beats.
module mem_stage #(
    parameter int BM_W  = 1536,
    parameter int BUS_W = 128
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_ld,
    input  logic             in_st,
    input  logic             in_ldb,
    input  logic             in_stb,
    input  logic [15:0]      in_addr,
    input  logic [15:0]      in_st_data,
    input  logic [BM_W-1:0]  in_bm_data,
    input  logic [3:0]       in_rd_addr,
    input  logic             in_rd_we,
    input  logic [1:0]       in_bd_addr,
    input  logic             in_bd_we,
    output logic             stall,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic [15:0]      dmem_addr,
    output logic [15:0]      dmem_wdata,
    input  logic [15:0]      dmem_rdata,
    input  logic             dmem_ack,
    output logic             bmem_req,
    output logic             bmem_we,
    output logic [15:0]      bmem_addr,
    output logic [BUS_W-1:0] bmem_wdata,
    input  logic [BUS_W-1:0] bmem_rdata,
    input  logic             bmem_ack,
    output logic             wb_valid,
    output logic             wb_rd_we,
    output logic [3:0]       wb_rd_addr,
    output logic [15:0]      wb_rd_data,
    output logic             wb_bd_we,
    output logic [1:0]       wb_bd_addr,
    output logic [BM_W-1:0]  wb_bd_data
);

    localparam int BEATS  = BM_W / BUS_W;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    typedef enum logic [1:0] {IDLE, DBUSY, BBUSY} state_t;

    state_t state, state_next;

    logic              memop;
    logic              pick_bm;
    logic              pick_stb;
    logic              pick_st;
    logic              last_beat;

    logic [15:0]       lat_addr;
    logic [15:0]       lat_st_data;
    logic [BM_W-1:0]   lat_bm;
    logic              lat_st;
    logic              lat_stb;
    logic [3:0]        lat_rd_addr;
    logic              lat_rd_we;
    logic [1:0]        lat_bd_addr;
    logic              lat_bd_we;

    logic [BEAT_W-1:0] beat;
    logic [BM_W-1:0]   load_buf;
    logic [BM_W-1:0]   ldb_full;

    // Decode priority ldb > stb > ld > st falls out of these masks.
    assign memop     = in_valid & (in_ld | in_st | in_ldb | in_stb);
    assign pick_bm   = in_ldb | in_stb;
    assign pick_stb  = ~in_ldb & in_stb;
    assign pick_st   = ~in_ld & in_st;
    assign last_beat = (beat == LAST_BEAT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        stall      = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        dmem_addr  = '0;
        dmem_wdata = '0;
        bmem_req   = 1'b0;
        bmem_we    = 1'b0;
        bmem_addr  = '0;
        bmem_wdata = '0;
        case (state)
            IDLE: begin
                if (memop) begin
                    stall      = 1'b1;
                    state_next = pick_bm ? BBUSY : DBUSY;
                end
            end
            DBUSY: begin
                dmem_req   = 1'b1;
                dmem_we    = lat_st;
                dmem_addr  = lat_addr;
                dmem_wdata = lat_st_data;
                stall      = ~dmem_ack;
                if (dmem_ack) begin
                    state_next = IDLE;
                end
            end
            BBUSY: begin
                bmem_req   = 1'b1;
                bmem_we    = lat_stb;
                bmem_addr  = lat_addr + 16'(beat);
                bmem_wdata = lat_bm[int'(beat)*BUS_W +: BUS_W];
                stall      = ~(bmem_ack & last_beat);
                if (bmem_ack && last_beat) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        // Reset must silence stall even while upstream still presents a memop.
        if (rst) begin
            stall = 1'b0;
        end
    end

    // The final beat bypasses the buffer so writeback sees it on the completing edge.
    always_comb begin
        ldb_full = load_buf;
        ldb_full[(BEATS-1)*BUS_W +: BUS_W] = bmem_rdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_addr    <= '0;
            lat_st_data <= '0;
            lat_bm      <= '0;
            lat_st      <= 1'b0;
            lat_stb     <= 1'b0;
            lat_rd_addr <= '0;
            lat_rd_we   <= 1'b0;
            lat_bd_addr <= '0;
            lat_bd_we   <= 1'b0;
            beat        <= '0;
            load_buf    <= '0;
            wb_valid    <= 1'b0;
            wb_rd_we    <= 1'b0;
            wb_rd_addr  <= '0;
            wb_rd_data  <= '0;
            wb_bd_we    <= 1'b0;
            wb_bd_addr  <= '0;
            wb_bd_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (memop) begin
                        lat_addr    <= in_addr;
                        lat_st_data <= in_st_data;
                        lat_bm      <= in_bm_data;
                        lat_st      <= pick_st;
                        lat_stb     <= pick_stb;
                        lat_rd_addr <= in_rd_addr;
                        lat_rd_we   <= in_rd_we;
                        lat_bd_addr <= in_bd_addr;
                        lat_bd_we   <= in_bd_we;
                        beat        <= '0;
                        wb_valid    <= 1'b0;
                    end else if (in_valid) begin
                        wb_valid   <= 1'b1;
                        wb_rd_we   <= in_rd_we;
                        wb_rd_addr <= in_rd_addr;
                        wb_rd_data <= in_addr;
                        wb_bd_we   <= in_bd_we;
                        wb_bd_addr <= in_bd_addr;
                        wb_bd_data <= in_bm_data;
                    end else begin
                        wb_valid <= 1'b0;
                    end
                end
                DBUSY: begin
                    if (dmem_ack) begin
                        wb_valid   <= 1'b1;
                        wb_rd_addr <= lat_rd_addr;
                        wb_bd_addr <= lat_bd_addr;
                        wb_bd_we   <= 1'b0;
                        if (lat_st) begin
                            wb_rd_we <= 1'b0;
                        end else begin
                            wb_rd_we   <= lat_rd_we;
                            wb_rd_data <= dmem_rdata;
                        end
                    end else begin
                        wb_valid <= 1'b0;
                    end
                end
                BBUSY: begin
                    wb_valid <= 1'b0;
                    if (bmem_ack) begin
                        if (!lat_stb) begin
                            load_buf[int'(beat)*BUS_W +: BUS_W] <= bmem_rdata;
                        end
                        if (last_beat) begin
                            beat       <= '0;
                            wb_valid   <= 1'b1;
                            wb_rd_we   <= 1'b0;
                            wb_rd_addr <= lat_rd_addr;
                            wb_bd_addr <= lat_bd_addr;
                            if (lat_stb) begin
                                wb_bd_we <= 1'b0;
                            end else begin
                                wb_bd_we   <= lat_bd_we;
                                wb_bd_data <= ldb_full;
                            end
                        end else begin
                            beat <= beat + BEAT_W'(1);
                        end
                    end
                end
                default: begin
                    wb_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: queued writeback and bus expectations, popped as the DUT produces them.
// Memory models answer with configurable wait states (scalar) or every-other-cycle gaps (bitmap).
module tb_mem_stage;

    localparam int BM_W   = 1536;
    localparam int BUS_W  = 128;
    localparam int BEATS  = 12;
    localparam int BUDGET = 100;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ld = 1'b0;
    logic             in_st = 1'b0;
    logic             in_ldb = 1'b0;
    logic             in_stb = 1'b0;
    logic [15:0]      in_addr = '0;
    logic [15:0]      in_st_data = '0;
    logic [BM_W-1:0]  in_bm_data = '0;
    logic [3:0]       in_rd_addr = '0;
    logic             in_rd_we = 1'b0;
    logic [1:0]       in_bd_addr = '0;
    logic             in_bd_we = 1'b0;
    logic             stall;
    logic             dmem_req, dmem_we;
    logic [15:0]      dmem_addr, dmem_wdata;
    logic [15:0]      dmem_rdata = '0;
    logic             dmem_ack = 1'b0;
    logic             bmem_req, bmem_we;
    logic [15:0]      bmem_addr;
    logic [BUS_W-1:0] bmem_wdata;
    logic [BUS_W-1:0] bmem_rdata = '0;
    logic             bmem_ack = 1'b0;
    logic             wb_valid, wb_rd_we, wb_bd_we;
    logic [3:0]       wb_rd_addr;
    logic [15:0]      wb_rd_data;
    logic [1:0]       wb_bd_addr;
    logic [BM_W-1:0]  wb_bd_data;

    mem_stage #(.BM_W(BM_W), .BUS_W(BUS_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ld(in_ld), .in_st(in_st), .in_ldb(in_ldb), .in_stb(in_stb),
        .in_addr(in_addr), .in_st_data(in_st_data), .in_bm_data(in_bm_data),
        .in_rd_addr(in_rd_addr), .in_rd_we(in_rd_we), .in_bd_addr(in_bd_addr), .in_bd_we(in_bd_we),
        .stall(stall),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .bmem_req(bmem_req), .bmem_we(bmem_we), .bmem_addr(bmem_addr), .bmem_wdata(bmem_wdata),
        .bmem_rdata(bmem_rdata), .bmem_ack(bmem_ack),
        .wb_valid(wb_valid), .wb_rd_we(wb_rd_we), .wb_rd_addr(wb_rd_addr), .wb_rd_data(wb_rd_data),
        .wb_bd_we(wb_bd_we), .wb_bd_addr(wb_bd_addr), .wb_bd_data(wb_bd_data)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    typedef struct {
        logic            valid, ld, st, ldb, stb;
        logic [15:0]     addr, st_data;
        logic [BM_W-1:0] bm;
        logic [3:0]      rd_addr;
        logic            rd_we;
        logic [1:0]      bd_addr;
        logic            bd_we;
    } op_t;

    typedef struct {
        logic            rd_we;
        logic [3:0]      rd_addr;
        logic [15:0]     rd_data;
        logic            chk_rd_data;
        logic            bd_we;
        logic            chk_bd_we;
        logic [1:0]      bd_addr;
        logic [BM_W-1:0] bd_data;
        logic            chk_bd_data;
    } wb_exp_t;

    typedef struct {
        logic [15:0]      addr;
        logic             we;
        logic [BUS_W-1:0] wdata;
    } bus_exp_t;

    wb_exp_t  wb_q[$];
    bus_exp_t dmem_q[$];
    bus_exp_t bmem_q[$];
    wb_exp_t  wb_e;

    int          dwait = 0;
    int          dcnt = 0;
    logic [15:0] drval = '0;
    logic        bgap = 1'b0;
    logic        bphase = 1'b0;
    logic [15:0] bm_base = '0;
    logic [15:0] bk;
    int          dreq_cycles = 0;
    int          breq_cycles = 0;

    function automatic op_t mkOp(input logic ld, st, ldb, stb, input logic [15:0] addr, st_data,
                                 input logic [3:0] rd_addr, input logic rd_we,
                                 input logic [1:0] bd_addr, input logic bd_we);
        op_t o;
        o.valid = 1'b1; o.ld = ld; o.st = st; o.ldb = ldb; o.stb = stb;
        o.addr = addr; o.st_data = st_data; o.rd_addr = rd_addr; o.rd_we = rd_we;
        o.bd_addr = bd_addr; o.bd_we = bd_we;
        for (int i = 0; i < BM_W/32; i++) o.bm[i*32 +: 32] = $urandom;
        return o;
    endfunction

    function automatic wb_exp_t mkWb(input logic rd_we, input logic [3:0] rd_addr,
                                     input logic [15:0] rd_data, input logic chk_rd_data,
                                     input logic bd_we, input logic chk_bd_we, input logic [1:0] bd_addr,
                                     input logic [BM_W-1:0] bd_data, input logic chk_bd_data);
        wb_exp_t w;
        w.rd_we = rd_we; w.rd_addr = rd_addr; w.rd_data = rd_data; w.chk_rd_data = chk_rd_data;
        w.bd_we = bd_we; w.chk_bd_we = chk_bd_we; w.bd_addr = bd_addr;
        w.bd_data = bd_data; w.chk_bd_data = chk_bd_data;
        return w;
    endfunction

    task automatic driveIdle();
        in_valid = 1'b0; in_ld = 1'b0; in_st = 1'b0; in_ldb = 1'b0; in_stb = 1'b0;
    endtask

    task automatic driveOp(input op_t o);
        in_valid = o.valid; in_ld = o.ld; in_st = o.st; in_ldb = o.ldb; in_stb = o.stb;
        in_addr = o.addr; in_st_data = o.st_data; in_bm_data = o.bm;
        in_rd_addr = o.rd_addr; in_rd_we = o.rd_we; in_bd_addr = o.bd_addr; in_bd_we = o.bd_we;
    endtask

    // Called just after a falling edge; holds the op until stall releases, then goes idle.
    task automatic applyStimulus(input op_t o, input int exp_stall, input string tag);
        int n;
        driveOp(o);
        n = 0;
        #1;
        while (stall && n < BUDGET) begin
            n++;
            @(negedge clk);
            #1;
        end
        checkOutput({tag, "_stall_cycles"}, 128'(n), 128'(exp_stall));
        @(negedge clk);
        driveIdle();
    endtask

    // Memory models plus request checking against the bus scoreboards.
    always @(negedge clk) begin
        if (dmem_req) begin
            dreq_cycles++;
            checkOutput("dmem_expected", 128'(dmem_q.size() != 0), 128'(1));
            if (dmem_q.size() != 0) begin
                checkOutput("dmem_addr", dmem_addr, dmem_q[0].addr);
                checkOutput("dmem_we", dmem_we, dmem_q[0].we);
                if (dmem_q[0].we) checkOutput("dmem_wdata", dmem_wdata, dmem_q[0].wdata[15:0]);
            end
            if (dcnt >= dwait) begin
                dmem_ack = 1'b1;
                dmem_rdata = drval;
                dcnt = 0;
                if (dmem_q.size() != 0) dmem_q.delete(0);
            end else begin
                dmem_ack = 1'b0;
                dmem_rdata = '0;
                dcnt++;
            end
        end else begin
            dmem_ack = 1'b0;
            dcnt = 0;
        end
        if (bmem_req) begin
            breq_cycles++;
            checkOutput("bmem_expected", 128'(bmem_q.size() != 0), 128'(1));
            if (bmem_q.size() != 0) begin
                checkOutput("bmem_addr", bmem_addr, bmem_q[0].addr);
                checkOutput("bmem_we", bmem_we, bmem_q[0].we);
                if (bmem_q[0].we) checkOutput("bmem_wdata", bmem_wdata, bmem_q[0].wdata);
            end
            if (bgap && !bphase) begin
                bmem_ack = 1'b0;
                bphase = 1'b1;
            end else begin
                bmem_ack = 1'b1;
                bk = bmem_addr - bm_base;
                bmem_rdata = {16{bk[7:0]}};
                bphase = 1'b0;
                if (bmem_q.size() != 0) bmem_q.delete(0);
            end
        end else begin
            bmem_ack = 1'b0;
            bphase = 1'b0;
        end
    end

    // Writeback monitor: every valid entry must match the oldest expectation.
    always @(negedge clk) begin
        if (wb_valid) begin
            checkOutput("wb_expected", 128'(wb_q.size() != 0), 128'(1));
            if (wb_q.size() != 0) begin
                wb_e = wb_q.pop_front();
                checkOutput("wb_rd_we", wb_rd_we, wb_e.rd_we);
                if (wb_e.rd_we) checkOutput("wb_rd_addr", wb_rd_addr, wb_e.rd_addr);
                if (wb_e.chk_rd_data) checkOutput("wb_rd_data", wb_rd_data, wb_e.rd_data);
                if (wb_e.chk_bd_we) checkOutput("wb_bd_we", wb_bd_we, wb_e.bd_we);
                if (wb_e.bd_we) checkOutput("wb_bd_addr", wb_bd_addr, wb_e.bd_addr);
                if (wb_e.chk_bd_data) begin
                    for (int k = 0; k < BEATS; k++)
                        checkOutput($sformatf("wb_bd_data[%0d]", k), wb_bd_data[k*BUS_W +: BUS_W],
                                    wb_e.bd_data[k*BUS_W +: BUS_W]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        op_t             o;
        bus_exp_t        b;
        logic [BM_W-1:0] pat;
        int              i;

        // Reset state, with a memop presented to prove stall stays low under reset.
        #12;
        in_valid = 1'b1; in_ld = 1'b1;
        #1;
        checkOutput("rst_wb_valid", wb_valid, 1'b0);
        checkOutput("rst_stall", stall, 1'b0);
        checkOutput("rst_dmem_req", dmem_req, 1'b0);
        checkOutput("rst_bmem_req", bmem_req, 1'b0);
        checkOutput("rst_wb_rd_data", wb_rd_data, 16'h0);
        checkOutput("rst_wb_bd_data0", wb_bd_data[BUS_W-1:0], '0);
        driveIdle();
        @(negedge clk);
        rst = 1'b0;

        o = mkOp(0, 0, 0, 0, 16'h1234, 16'h0, 4'd5, 1'b1, 2'd2, 1'b1);
        wb_q.push_back(mkWb(1'b1, 4'd5, 16'h1234, 1'b1, 1'b1, 1'b1, 2'd2, o.bm, 1'b1));
        applyStimulus(o, 0, "alu");

        dwait = 2; drval = 16'hBEEF; dreq_cycles = 0;
        b.addr = 16'h0040; b.we = 1'b0; b.wdata = '0; dmem_q.push_back(b);
        o = mkOp(1, 0, 0, 0, 16'h0040, 16'h0, 4'd3, 1'b1, 2'd0, 1'b0);
        wb_q.push_back(mkWb(1'b1, 4'd3, 16'hBEEF, 1'b1, 1'b0, 1'b0, 2'd0, '0, 1'b0));
        applyStimulus(o, 3, "ld");
        checkOutput("ld_req_cycles", 128'(dreq_cycles), 128'(3));

        dwait = 0; dreq_cycles = 0;
        b.addr = 16'h0010; b.we = 1'b1; b.wdata = 128'h00A5; dmem_q.push_back(b);
        o = mkOp(0, 1, 0, 0, 16'h0010, 16'h00A5, 4'd6, 1'b1, 2'd1, 1'b1);
        wb_q.push_back(mkWb(1'b0, 4'd6, 16'h0, 1'b0, 1'b0, 1'b1, 2'd1, '0, 1'b0));
        applyStimulus(o, 1, "st");
        checkOutput("st_req_cycles", 128'(dreq_cycles), 128'(1));

        // ld wins over st when both are flagged.
        drval = 16'h5A5A;
        b.addr = 16'h0022; b.we = 1'b0; b.wdata = '0; dmem_q.push_back(b);
        o = mkOp(1, 1, 0, 0, 16'h0022, 16'hFFFF, 4'd7, 1'b1, 2'd0, 1'b0);
        wb_q.push_back(mkWb(1'b1, 4'd7, 16'h5A5A, 1'b1, 1'b0, 1'b0, 2'd0, '0, 1'b0));
        applyStimulus(o, 1, "ld_prio");

        // Bitmap load; the extra st flag must be ignored.
        bgap = 1'b0; bm_base = 16'h0100; breq_cycles = 0;
        for (i = 0; i < BEATS; i++) begin
            b.addr = 16'h0100 + 16'(i); b.we = 1'b0; b.wdata = '0; bmem_q.push_back(b);
            pat[i*BUS_W +: BUS_W] = {16{8'(i)}};
        end
        o = mkOp(0, 1, 1, 0, 16'h0100, 16'h0, 4'd0, 1'b0, 2'd1, 1'b1);
        wb_q.push_back(mkWb(1'b0, 4'd0, 16'h0, 1'b0, 1'b1, 1'b1, 2'd1, pat, 1'b1));
        applyStimulus(o, 12, "ldb");
        checkOutput("ldb_req_cycles", 128'(breq_cycles), 128'(12));

        // Bitmap load whose beat addresses wrap past 0xFFFF.
        bm_base = 16'hFFFA;
        for (i = 0; i < BEATS; i++) begin
            b.addr = 16'hFFFA + 16'(i); b.we = 1'b0; b.wdata = '0; bmem_q.push_back(b);
        end
        o = mkOp(0, 0, 1, 1, 16'hFFFA, 16'h0, 4'd0, 1'b0, 2'd3, 1'b1);
        wb_q.push_back(mkWb(1'b0, 4'd0, 16'h0, 1'b0, 1'b1, 1'b1, 2'd3, pat, 1'b1));
        applyStimulus(o, 12, "ldb_wrap");

        // Bitmap store with an idle bus cycle before every ack.
        bgap = 1'b1; bm_base = 16'h0300; breq_cycles = 0;
        o = mkOp(0, 0, 0, 1, 16'h0300, 16'h0, 4'd2, 1'b1, 2'd2, 1'b1);
        for (i = 0; i < BEATS; i++) begin
            b.addr = 16'h0300 + 16'(i); b.we = 1'b1; b.wdata = o.bm[i*BUS_W +: BUS_W];
            bmem_q.push_back(b);
        end
        wb_q.push_back(mkWb(1'b0, 4'd2, 16'h0, 1'b0, 1'b0, 1'b1, 2'd2, '0, 1'b0));
        applyStimulus(o, 24, "stb_gap");
        checkOutput("stb_req_cycles", 128'(breq_cycles), 128'(24));

        // Reset during beat 5 of a bitmap load: everything drops, no writeback.
        bgap = 1'b0; bm_base = 16'h0200;
        for (i = 0; i < BEATS; i++) begin
            b.addr = 16'h0200 + 16'(i); b.we = 1'b0; b.wdata = '0; bmem_q.push_back(b);
        end
        o = mkOp(0, 0, 1, 0, 16'h0200, 16'h0, 4'd0, 1'b0, 2'd1, 1'b1);
        driveOp(o);
        for (i = 0; i < 40 && !(bmem_req && bmem_addr == 16'h0205); i++) @(negedge clk);
        checkOutput("rst_mid_beat5_addr", bmem_addr, 16'h0205);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("rst_mid_bmem_req", bmem_req, 1'b0);
        checkOutput("rst_mid_stall", stall, 1'b0);
        checkOutput("rst_mid_wb_valid", wb_valid, 1'b0);
        driveIdle();
        bmem_q.delete();
        @(negedge clk);
        rst = 1'b0;

        dwait = 1; drval = 16'h1357; dreq_cycles = 0;
        b.addr = 16'h0080; b.we = 1'b0; b.wdata = '0; dmem_q.push_back(b);
        o = mkOp(1, 0, 0, 0, 16'h0080, 16'h0, 4'd9, 1'b1, 2'd0, 1'b0);
        wb_q.push_back(mkWb(1'b1, 4'd9, 16'h1357, 1'b1, 1'b0, 1'b0, 2'd0, '0, 1'b0));
        applyStimulus(o, 2, "ld_after_rst");
        checkOutput("ld_after_rst_req_cycles", 128'(dreq_cycles), 128'(2));

        repeat (3) @(negedge clk);
        checkOutput("wb_queue_drained", 128'(wb_q.size()), 128'(0));
        checkOutput("dmem_queue_drained", 128'(dmem_q.size()), 128'(0));
        checkOutput("bmem_queue_drained", 128'(bmem_q.size()), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Pipeline stage directly downstream of the execute stage.
- Consumes the execute result (ALU result or effective address), store data and the 1536-bit bitmap result.
- Performs scalar loads/stores on a 16-bit data memory and bitmap loads/stores on a narrower bitmap-memory bus over multiple beats, stalling the pipeline meanwhile.
- Registers results for the writeback stage.

Parameters:
- BM_W, 1536: bitmap register width.
- BUS_W, 128: bitmap-memory beat width; BM_W must be an integer multiple.
- BEATS, BM_W/BUS_W (12): beats per bitmap transfer; derived, not overridable.

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-high reset
in_valid  in  1  instruction present from execute stage
in_ld / in_st / in_ldb / in_stb  in  1 each  memory op decode
in_addr  in  16  execute result: effective address for memops, ALU result otherwise
in_st_data  in  16  scalar store data
in_bm_data  in  BM_W  bitmap result / bitmap store data
in_rd_addr  in  4  destination register
in_rd_we  in  1  scalar writeback enable
in_bd_addr  in  2  destination bitmap register
in_bd_we  in  1  bitmap writeback enable
stall  out  1  hold execute stage and all earlier stages
dmem_req / dmem_we  out  1 each  data memory request / write
dmem_addr  out  16  data memory word address
dmem_wdata  out  16  data memory write data
dmem_rdata  in  16  data memory read data
dmem_ack  in  1  data memory completion
bmem_req / bmem_we  out  1 each  bitmap memory request / write
bmem_addr  out  16  bitmap memory beat address
bmem_wdata  out  BUS_W  bitmap beat write data
bmem_rdata  in  BUS_W  bitmap beat read data
bmem_ack  in  1  bitmap beat completion
wb_valid  out  1  writeback entry valid
wb_rd_we  out  1  scalar writeback enable
wb_rd_addr  out  4  scalar destination
wb_rd_data  out  16  scalar writeback data
wb_bd_we  out  1  bitmap writeback enable
wb_bd_addr  out  2  bitmap destination
wb_bd_data  out  BM_W  bitmap writeback data

Behaviour:
- **Reset.** Asynchronous; all outputs go 0 immediately. FSM goes to IDLE, beat counter to 0, load buffer to 0.
  - Reset mid-transfer abandons it: req drops with no completion and no wb_valid.
- **FSM states:** IDLE, DBUSY, BBUSY.
- **Op decode.** memop = in_valid & (ld|st|ldb|stb). Priority when several flags are set: ldb > stb > ld > st; the others are ignored.
- **Non-memop** (in_valid, no memop) in IDLE:
  - stall=0.
  - Next edge: wb_valid=1; wb_rd_* and wb_bd_* copy the inputs, with wb_rd_data=in_addr and wb_bd_data=in_bm_data.
  - Latency 1 cycle.
- **Idle cycle** (in_valid=0) in IDLE: next edge wb_valid=0; the other wb_* outputs hold their values.
- **Accept cycle** (memop in IDLE): stall=1. On the edge, latch address, data, op and dests; go to DBUSY (ld/st) or BBUSY (ldb/stb); wb_valid=0.
- **Upstream hold rule.** Upstream holds all in_* stable while stall=1. The block uses only latched copies once busy.
- **stall** is combinational:
  - 1 when (IDLE & memop), or when busy and the final ack has not arrived this cycle.
  - 0 in the cycle the final ack is sampled high, so upstream advances on that same edge.
- **DBUSY:**
  - dmem_req=1, dmem_addr=latched addr, dmem_we=st, dmem_wdata=latched st_data.
  - All held stable until dmem_ack=1; ack may be high in the first DBUSY cycle.
  - On the ack edge, go to IDLE and set wb_valid=1.
  - ld: wb_rd_data=dmem_rdata, wb_rd_we=latched rd_we.
  - st: wb_rd_we=0, wb_bd_we=0.
- **BBUSY:**
  - bmem_req=1 continuously, bmem_addr=latched addr+beat (16-bit wrap), bmem_we=stb.
  - bmem_wdata=latched bitmap bits [beat*BUS_W +: BUS_W]; beat 0 carries bits [BUS_W-1:0].
  - Each sampled bmem_ack advances the beat; ldb stores bmem_rdata into buffer slice [beat*BUS_W +: BUS_W].
  - Ack on beat BEATS-1: go to IDLE, clear beat, set wb_valid=1.
  - ldb: wb_bd_data=full buffer including the final beat, wb_bd_we=latched bd_we, wb_rd_we=0.
  - stb: wb_bd_we=0, wb_rd_we=0.
- **Stray acks.** dmem_ack / bmem_ack are ignored unless the matching req=1. In IDLE both reqs are 0.
- **Timing, zero-wait memory:** ld/st occupy 2 cycles (1 stall cycle); ldb/stb occupy BEATS+1=13 cycles (12 stall cycles).
- **Throughput.** Back-to-back memops are accepted: the next one is accepted in the cycle after IDLE is re-entered.

Test Plan:
- **ALU passthrough.** in_valid, no memop, in_addr=0x1234, rd_addr=5, rd_we=1 -> stall=0; next cycle wb_valid=1, wb_rd_data=0x1234, wb_rd_addr=5.
- **Scalar load.** ld addr=0x0040; dmem_ack after 2 wait cycles with rdata=0xBEEF -> dmem_addr=0x0040 stable with req held 3 cycles; stall high 3 cycles; then wb_rd_data=0xBEEF, wb_valid=1 for 1 cycle.
- **Scalar store.** st addr=0x0010, data=0x00A5, zero-wait -> exactly one dmem cycle with we=1, wdata=0x00A5; wb_valid=1 with wb_rd_we=0.
- **Bitmap load.** ldb addr=0x0100, zero-wait, beat k returns {16{k[7:0]}} -> bmem_addr 0x0100..0x010B; stall exactly 12 cycles; wb_bd_data slice k equals the pattern.
- **Bitmap store with gaps.** stb with bmem_ack low on every other cycle -> each beat's wdata/addr held until its ack; 12 writes in order; 24 busy cycles; wb_bd_we=0.
- **Reset mid-transfer.** Assert rst during ldb beat 5 -> bmem_req and stall drop immediately, no wb_valid. After release, a fresh ld completes normally.
